// File: rtl/mmio_map_pkg.sv
// Data-memory address map shared by the MMIO peripherals and the register
// decoder used by the switch reader.
package mmio_map_pkg;

  localparam logic [31:0] LED_ADDR  = 32'h0000_0100;
  localparam logic [31:0] SW_BASE   = 32'h0000_0200;

  localparam logic [31:0] OFF_LEVEL = 32'h0000_0000;
  localparam logic [31:0] OFF_EDGE  = 32'h0000_0004;
  localparam logic [31:0] OFF_COUNT = 32'h0000_0008;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_LEVEL,
    REG_EDGE,
    REG_COUNT
  } reg_sel_e;

  // Full 32-bit compare; anything outside the three registers maps to REG_NONE.
  function automatic reg_sel_e reg_decode(input logic [31:0] addr, input logic [31:0] base);
    reg_sel_e sel;
    sel = REG_NONE;
    if (addr == base + OFF_LEVEL) sel = REG_LEVEL;
    else if (addr == base + OFF_EDGE) sel = REG_EDGE;
    else if (addr == base + OFF_COUNT) sel = REG_COUNT;
    return sel;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch input: 2-flop synchroniser, stability counter and debounced level,
// plus a combinational pulse on the cycle the level is about to rise.
module debounce_bit #(
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rstn,
  input  logic sw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          flip;

  // Flip after DB_CYCLES consecutive mismatched cycles; counter stops at LAST.
  assign flip = (sync2 != level) && (cnt == LAST);
  assign rise = flip && !level;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (flip) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_switch_reader.sv
// Memory-mapped switch input block: debounced levels, sticky W1C rising-edge
// flags, a 16-bit press counter and a registered read port.
module mmio_switch_reader
  import mmio_map_pkg::*;
#(
  parameter int unsigned N_IN      = 8,
  parameter int unsigned DB_CYCLES = 500000,
  parameter logic [31:0] BASE_ADDR = SW_BASE
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N_IN-1:0] sw_in,
  input  logic            dmem_rd,
  input  logic [31:0]     dmem_raddr,
  output logic [31:0]     dmem_rdata,
  input  logic            dmem_wr,
  input  logic [31:0]     dmem_waddr,
  input  logic [31:0]     dmem_wdata,
  output logic            irq
);

  logic [N_IN-1:0] level;
  logic [N_IN-1:0] rise;
  logic [N_IN-1:0] edge_flag;
  logic [N_IN-1:0] clr_mask;
  logic [15:0]     press_cnt;
  logic [15:0]     rise_cnt;
  logic [31:0]     rd_mux;
  reg_sel_e        rd_sel;
  reg_sel_e        wr_sel;
  logic            unused_wdata;

  assign unused_wdata = &{1'b0, dmem_wdata[31:16]};

  for (genvar g = 0; g < N_IN; g++) begin : g_db
    debounce_bit #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk  (clk),
      .rstn (rstn),
      .sw   (sw_in[g]),
      .level(level[g]),
      .rise (rise[g])
    );
  end

  assign rd_sel = reg_decode(dmem_raddr, BASE_ADDR);
  assign wr_sel = reg_decode(dmem_waddr, BASE_ADDR);

  always_comb begin
    rise_cnt = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      rise_cnt = rise_cnt + {15'b0, rise[i]};
    end
  end

  always_comb begin
    clr_mask = '0;
    if (dmem_wr && wr_sel == REG_EDGE) clr_mask = dmem_wdata[N_IN-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      REG_LEVEL: rd_mux = 32'(level);
      REG_EDGE:  rd_mux = 32'(edge_flag);
      REG_COUNT: rd_mux = {16'b0, press_cnt};
      default:   rd_mux = '0;
    endcase
  end

  // Set beats clear on the flags; a COUNT write discards same-cycle presses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      edge_flag  <= '0;
      press_cnt  <= '0;
      irq        <= 1'b0;
      dmem_rdata <= '0;
    end else begin
      edge_flag <= (edge_flag & ~clr_mask) | rise;
      if (dmem_wr && wr_sel == REG_COUNT) press_cnt <= dmem_wdata[15:0];
      else                                 press_cnt <= press_cnt + rise_cnt;
      irq <= |edge_flag;
      if (dmem_rd) dmem_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_mmio_switch_reader.sv
// Scenario bench for mmio_switch_reader with DB_CYCLES=4, N_IN=8.
module tb_mmio_switch_reader;

  localparam int unsigned N_IN = 8;
  localparam int unsigned DB   = 4;
  localparam logic [31:0] BASE = 32'h0000_0200;
  localparam logic [31:0] A_LEVEL = BASE + 32'h0;
  localparam logic [31:0] A_EDGE  = BASE + 32'h4;
  localparam logic [31:0] A_COUNT = BASE + 32'h8;

  logic            clk;
  logic            rstn;
  logic [N_IN-1:0] sw_in;
  logic            dmem_rd;
  logic [31:0]     dmem_raddr;
  logic [31:0]     dmem_rdata;
  logic            dmem_wr;
  logic [31:0]     dmem_waddr;
  logic [31:0]     dmem_wdata;
  logic            irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       nm_q[$];
  logic [31:0] exp_v;
  string       nm;

  mmio_switch_reader #(
    .N_IN(N_IN),
    .DB_CYCLES(DB),
    .BASE_ADDR(BASE)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .sw_in     (sw_in),
    .dmem_rd   (dmem_rd),
    .dmem_raddr(dmem_raddr),
    .dmem_rdata(dmem_rdata),
    .dmem_wr   (dmem_wr),
    .dmem_waddr(dmem_waddr),
    .dmem_wdata(dmem_wdata),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one read strobe and record what the register must return.
  task automatic issue_read(input logic [31:0] a, input logic [31:0] e, input string n);
    dmem_rd    = 1'b1;
    dmem_raddr = a;
    exp_q.push_back(e);
    nm_q.push_back(n);
    tick(1);
    dmem_rd = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    dmem_wr    = 1'b1;
    dmem_waddr = a;
    dmem_wdata = d;
    tick(1);
    dmem_wr = 1'b0;
  endtask

  task automatic test_reset;
    rstn  = 1'b0;
    sw_in = 8'hFF;
    tick(3);
    checks++; if (dmem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected %h", dmem_rdata, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    rstn = 1'b1;
    tick(5);
    issue_read(A_LEVEL, 32'h00, "level_edge6");
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
    issue_read(A_LEVEL, 32'hFF, "level_after_reset");
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
    issue_read(A_EDGE, 32'hFF, "edge_after_reset");
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
    issue_read(A_COUNT, 32'h8, "count_after_reset");
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_reset: got %b expected 1", irq); end
  endtask

  task automatic test_glitch;
    sw_in = 8'h00;
    tick(10);
    bus_write(A_EDGE, 32'hFF);
    tick(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %b expected 0", irq); end
    sw_in[0] = 1'b1;
    tick(3);
    sw_in[0] = 1'b0;
    tick(10);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL glitch_irq: got %b expected 0", irq); end
    issue_read(A_LEVEL, 32'h00, "glitch_level");
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
    issue_read(A_EDGE, 32'h00, "glitch_edge");
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
    issue_read(A_COUNT, 32'h8, "glitch_count");
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
  endtask

  task automatic test_step;
    sw_in[3] = 1'b1;
    tick(5);
    issue_read(A_LEVEL, 32'h00, "step_level_edge6");
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL step_irq_early: got %b expected 0", irq); end
    issue_read(A_LEVEL, 32'h08, "step_level_edge7");
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL step_irq: got %b expected 1", irq); end
    issue_read(A_EDGE, 32'h08, "step_edge");
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
    issue_read(A_COUNT, 32'h9, "step_count");
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
  endtask

  task automatic test_w1c;
    sw_in[3] = 1'b0;
    tick(10);
    sw_in[3] = 1'b1;
    tick(5);
    bus_write(A_EDGE, 32'h08);
    issue_read(A_EDGE, 32'h08, "w1c_vs_rise");
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
    issue_read(A_COUNT, 32'hA, "w1c_count");
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
    dmem_wr    = 1'b1;
    dmem_waddr = A_EDGE;
    dmem_wdata = 32'h08;
    issue_read(A_EDGE, 32'h08, "read_during_w1c");
    dmem_wr = 1'b0;
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
    issue_read(A_EDGE, 32'h00, "edge_after_w1c");
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_w1c: got %b expected 0", irq); end
  endtask

  task automatic test_count_wrap;
    bus_write(A_COUNT, 32'h0000_FFFF);
    issue_read(A_COUNT, 32'hFFFF, "count_loaded");
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
    sw_in[5] = 1'b1;
    tick(8);
    issue_read(A_COUNT, 32'h0, "count_wrap");
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
    issue_read(BASE + 32'hC, 32'h0, "unmapped_020c");
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
    issue_read(32'h0000_0100, 32'h0, "unmapped_0100");
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
    sw_in[6] = 1'b1;
    tick(5);
    bus_write(A_COUNT, 32'hABCD_1234);
    issue_read(A_COUNT, 32'h1234, "count_write_vs_edge");
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
    tick(3);
    checks++; if (dmem_rdata !== 32'h1234) begin errors++; $display("FAIL rdata_hold: got %h expected %h", dmem_rdata, 32'h1234); end
    issue_read(A_EDGE, 32'h60, "edge_bits56");
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
  endtask

  task automatic test_reset_mid;
    issue_read(A_LEVEL, 32'h68, "level_before_reset");
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
    sw_in[1] = 1'b1;
    tick(4);
    rstn = 1'b0;
    #1;
    checks++; if (dmem_rdata !== 32'h0) begin errors++; $display("FAIL midreset_rdata: got %h expected %h", dmem_rdata, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b expected 0", irq); end
    tick(2);
    rstn = 1'b1;
    tick(5);
    issue_read(A_LEVEL, 32'h00, "rerelease_level_edge6");
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
    issue_read(A_LEVEL, 32'h6A, "rerelease_level_edge7");
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
    issue_read(A_EDGE, 32'h6A, "rerelease_edge");
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
    issue_read(A_COUNT, 32'h4, "rerelease_count");
    exp_v = exp_q.pop_front(); nm = nm_q.pop_front(); checks++;
    if (dmem_rdata !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", nm, dmem_rdata, exp_v); end
  endtask

  initial begin
    rstn       = 1'b0;
    sw_in      = '0;
    dmem_rd    = 1'b0;
    dmem_raddr = '0;
    dmem_wr    = 1'b0;
    dmem_waddr = '0;
    dmem_wdata = '0;
    test_reset();
    test_glitch();
    test_step();
    test_w1c();
    test_count_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
